// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the MIPS fetch path.
//   pcsrc_e        - next-PC select encodings driven by the control unit
//   fetch_state_e  - fetch state machine states
//   HALT_OP_DEFAULT- opcode field value that stops fetch
package cpu_pkg;

   typedef enum logic [1:0] {
      PCSRC_SEQ = 2'b00,
      PCSRC_BR  = 2'b01,
      PCSRC_J   = 2'b10,
      PCSRC_JR  = 2'b11
   } pcsrc_e;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'b00,
      ST_RUN   = 2'b01,
      ST_HALT  = 2'b10,
      ST_FAULT = 2'b11
   } fetch_state_e;

   localparam logic [5:0] HALT_OP_DEFAULT = 6'b111111;

endpackage

// File: rtl/next_pc_mux.sv
// next_pc_mux: combinational next-PC target selection.
//   pc4      in  current PC + 4
//   pcsrc    in  select: seq / branch / jump / jr
//   imm32    in  sign-extended branch offset in words
//   jtarget  in  26-bit jump target field
//   regaddr  in  rs value for jr
//   next_pc  out selected target (modulo 2^32)
module next_pc_mux
   import cpu_pkg::*;
(
   input  logic [31:0] pc4,
   input  logic [1:0]  pcsrc,
   input  logic [31:0] imm32,
   input  logic [25:0] jtarget,
   input  logic [31:0] regaddr,
   output logic [31:0] next_pc
);

   always_comb begin
      next_pc = pc4;
      case (pcsrc_e'(pcsrc))
         PCSRC_SEQ: next_pc = pc4;
         PCSRC_BR:  next_pc = pc4 + (imm32 << 2);
         PCSRC_J:   next_pc = {pc4[31:28], jtarget, 2'b00};
         PCSRC_JR:  next_pc = regaddr;
         default:   next_pc = pc4;
      endcase
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch stage of the single-cycle MIPS core. Holds the PC,
// drives the instruction memory address, selects the next PC and freezes
// fetch on a halt opcode or an out-of-range / misaligned target.
//   CLK, nRST        clock, asynchronous active-low reset
//   PCWre            PC write enable (0 = stall)
//   PCSrc            next-PC select
//   Imm32, JTarget,
//   RegAddr          branch offset, jump field, jr register value
//   IDataIn          instruction currently fetched at IAddr
//   IAddr, PC4       current PC and PC+4
//   Halted, Fault    registered status flags
//   FetchCnt         count of PC updates (only with FETCH_COUNT_EN defined)
module pc_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_BYTES = 240,
   parameter logic [5:0]  HALT_OP    = HALT_OP_DEFAULT
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        PCWre,
   input  logic [1:0]  PCSrc,
   input  logic [31:0] Imm32,
   input  logic [25:0] JTarget,
   input  logic [31:0] RegAddr,
   input  logic [31:0] IDataIn,
   output logic [31:0] IAddr,
   output logic [31:0] PC4,
   output logic        Halted,
   output logic        Fault
`ifdef FETCH_COUNT_EN
   ,
   output logic [31:0] FetchCnt
`endif
);

   localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

   fetch_state_e state, state_nxt;
   logic [31:0]  pc, pc_nxt, next_pc;
   logic         halted, halted_nxt, fault, fault_nxt;
   logic         unused_idata;

   assign unused_idata = ^IDataIn[25:0];

   assign IAddr  = pc;
   assign PC4    = pc + 32'd4;
   assign Halted = halted;
   assign Fault  = fault;

   next_pc_mux u_next_pc_mux (
      .pc4     (PC4),
      .pcsrc   (PCSrc),
      .imm32   (Imm32),
      .jtarget (JTarget),
      .regaddr (RegAddr),
      .next_pc (next_pc)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= ST_BOOT;
         pc     <= RESET_PC;
         halted <= 1'b0;
         fault  <= 1'b0;
      end else begin
         state  <= state_nxt;
         pc     <= pc_nxt;
         halted <= halted_nxt;
         fault  <= fault_nxt;
      end
   end

   // Halt outranks fault; a wrapped PC4 (past FFFF_FFFC) lands in the range check.
   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      halted_nxt = halted;
      fault_nxt  = fault;
      case (state)
         ST_BOOT: state_nxt = ST_RUN;
         ST_RUN: begin
            if (PCWre) begin
               if (IDataIn[31:26] == HALT_OP) begin
                  state_nxt  = ST_HALT;
                  halted_nxt = 1'b1;
               end else if ((next_pc[1:0] != 2'b00) || (next_pc > LAST_PC)) begin
                  state_nxt = ST_FAULT;
                  fault_nxt = 1'b1;
               end else begin
                  pc_nxt = next_pc;
               end
            end
         end
         ST_HALT:  state_nxt = ST_HALT;
         ST_FAULT: state_nxt = ST_FAULT;
         default:  state_nxt = ST_BOOT;
      endcase
   end

`ifdef FETCH_COUNT_EN
   logic [31:0] fetch_cnt;
   logic        pc_adv;

   // A PC update is exactly a RUN edge that stays in RUN with PCWre high.
   assign pc_adv   = (state == ST_RUN) && (state_nxt == ST_RUN) && PCWre;
   assign FetchCnt = fetch_cnt;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         fetch_cnt <= '0;
      else if (pc_adv && (fetch_cnt != '1))
         fetch_cnt <= fetch_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        PCWre;
   logic [1:0]  PCSrc;
   logic [31:0] Imm32;
   logic [25:0] JTarget;
   logic [31:0] RegAddr;
   logic [31:0] IDataIn;
   logic [31:0] IAddr;
   logic [31:0] PC4;
   logic        Halted;
   logic        Fault;
`ifdef FETCH_COUNT_EN
   logic [31:0] FetchCnt;
`endif

   int compared   = 0;
   int mismatched = 0;

   localparam logic [31:0] NOP  = 32'h0000_0000;
   localparam logic [31:0] HALT = 32'hFC00_0000;

   pc_fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .IMEM_BYTES (240),
      .HALT_OP    (6'b111111)
   ) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .PCWre    (PCWre),
      .PCSrc    (PCSrc),
      .Imm32    (Imm32),
      .JTarget  (JTarget),
      .RegAddr  (RegAddr),
      .IDataIn  (IDataIn),
      .IAddr    (IAddr),
      .PC4      (PC4),
      .Halted   (Halted),
      .Fault    (Fault)
`ifdef FETCH_COUNT_EN
      ,
      .FetchCnt (FetchCnt)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full status check: PC, PC+4 and both flags.
   task automatic chk_all(input string tag, input logic [31:0] pc, input logic h, input logic f);
      chk({tag, ".IAddr"}, IAddr, pc);
      chk({tag, ".PC4"}, PC4, pc + 32'd4);
      chk({tag, ".Halted"}, {31'd0, Halted}, {31'd0, h});
      chk({tag, ".Fault"}, {31'd0, Fault}, {31'd0, f});
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Pulse reset away from the clock edge, then release on a falling edge.
   task automatic do_reset();
      @(negedge CLK);
      nRST = 1'b0;
      #1;
      chk_all("rst", 32'h0, 1'b0, 1'b0);
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   initial begin
      nRST    = 1'b0;
      PCWre   = 1'b1;
      PCSrc   = 2'b00;
      Imm32   = '0;
      JTarget = '0;
      RegAddr = '0;
      IDataIn = NOP;
      #12;
      chk_all("reset", 32'h0, 1'b0, 1'b0);
      @(negedge CLK);
      nRST = 1'b1;

      // Sequential fetch: BOOT edge holds 0, then +4 per edge
      step(); chk_all("boot", 32'h00, 1'b0, 1'b0);
      step(); chk_all("seq1", 32'h04, 1'b0, 1'b0);
      step(); chk_all("seq2", 32'h08, 1'b0, 1'b0);
      step(); chk_all("seq3", 32'h0C, 1'b0, 1'b0);
      step(); chk_all("seq4", 32'h10, 1'b0, 1'b0);

      // Branch at 0x10 with -3 words: 0x14 - 12 = 0x08
      PCSrc = 2'b01; Imm32 = 32'hFFFF_FFFD;
      step(); chk_all("branch", 32'h08, 1'b0, 1'b0);

      // Jump at 0x08 to word 8: {0, 8, 00} = 0x20
      PCSrc = 2'b10; JTarget = 26'h000_0008;
      step(); chk_all("jump", 32'h20, 1'b0, 1'b0);

      // Stall three edges with a pending jump elsewhere
      PCWre = 1'b0; JTarget = 26'h000_0010;
      step(); chk_all("stall1", 32'h20, 1'b0, 1'b0);
      step(); chk_all("stall2", 32'h20, 1'b0, 1'b0);
      step(); chk_all("stall3", 32'h20, 1'b0, 1'b0);

      // jr to 0x40
      PCWre = 1'b1; PCSrc = 2'b11; RegAddr = 32'h40;
      step(); chk_all("jr", 32'h40, 1'b0, 1'b0);

      // Halt opcode while stalled is not evaluated
      PCSrc = 2'b00; IDataIn = HALT; PCWre = 1'b0;
      step(); chk_all("halt_stall", 32'h40, 1'b0, 1'b0);

      PCWre = 1'b1;
      step(); chk_all("halt", 32'h40, 1'b1, 1'b0);

      // Sticky halt ignores a legal jr target
      PCSrc = 2'b11; RegAddr = 32'h80; IDataIn = NOP;
      for (int i = 0; i < 5; i++) begin
         step(); chk_all("halt_hold", 32'h40, 1'b1, 1'b0);
      end

      // Mid-cycle reset out of HALT
      @(negedge CLK);
      #2;
      nRST = 1'b0;
      #1;
      chk_all("rst_mid", 32'h0, 1'b0, 1'b0);

      // Misaligned jr target
      PCSrc = 2'b11; RegAddr = 32'h42; IDataIn = NOP;
      @(negedge CLK);
      nRST = 1'b1;
      step(); chk_all("boot2", 32'h0, 1'b0, 1'b0);
      step(); chk_all("fault_mis", 32'h0, 1'b0, 1'b1);
      RegAddr = 32'h10;
      step(); chk_all("fault_hold", 32'h0, 1'b0, 1'b1);

      // Just past the last legal address
      RegAddr = 32'hF0;
      do_reset();
      step(); chk_all("boot3", 32'h0, 1'b0, 1'b0);
      step(); chk_all("fault_range", 32'h0, 1'b0, 1'b1);

      // Last legal address, then sequential step past it
      RegAddr = 32'hEC;
      do_reset();
      step(); chk_all("boot4", 32'h0, 1'b0, 1'b0);
      step(); chk_all("jr_last", 32'hEC, 1'b0, 1'b0);
      PCSrc = 2'b00;
      step(); chk_all("seq_past", 32'hEC, 1'b0, 1'b1);

      // Halt outranks a fault on the same edge
      PCSrc = 2'b11; RegAddr = 32'h42; IDataIn = HALT;
      do_reset();
      step(); chk_all("boot5", 32'h0, 1'b0, 1'b0);
      step(); chk_all("halt_prio", 32'h0, 1'b1, 1'b0);

      // Wrapped top-of-memory target faults
      RegAddr = 32'hFFFF_FFFC; IDataIn = NOP;
      do_reset();
      step(); chk_all("boot6", 32'h0, 1'b0, 1'b0);
      step(); chk_all("fault_top", 32'h0, 1'b0, 1'b1);

`ifdef FETCH_COUNT_EN
      PCSrc = 2'b00; IDataIn = NOP; PCWre = 1'b1;
      do_reset();
      chk("cnt_rst", FetchCnt, 32'd0);
      step(); chk("cnt_boot", FetchCnt, 32'd0);
      for (int i = 0; i < 10; i++) step();
      chk("cnt_adv", FetchCnt, 32'd10);
      chk("cnt_pc", IAddr, 32'h28);
      PCWre = 1'b0;
      step(); step();
      chk("cnt_stall", FetchCnt, 32'd10);
      PCWre = 1'b1; IDataIn = HALT;
      step(); chk("cnt_halt", FetchCnt, 32'd10);
      step(); step();
      chk("cnt_hold", FetchCnt, 32'd10);
      chk("cnt_halted", {31'd0, Halted}, 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
